// File: rtl/calendar_sequencer_pkg.sv
// Shared types and constants for the calendar sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calendar_sequencer_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 7;

  localparam logic [MONTH_W-1:0] JAN = 4'd1;
  localparam logic [MONTH_W-1:0] FEB = 4'd2;
  localparam logic [MONTH_W-1:0] MAR = 4'd3;
  localparam logic [MONTH_W-1:0] APR = 4'd4;
  localparam logic [MONTH_W-1:0] MAY = 4'd5;
  localparam logic [MONTH_W-1:0] JUN = 4'd6;
  localparam logic [MONTH_W-1:0] JUL = 4'd7;
  localparam logic [MONTH_W-1:0] AUG = 4'd8;
  localparam logic [MONTH_W-1:0] SEP = 4'd9;
  localparam logic [MONTH_W-1:0] OCT = 4'd10;
  localparam logic [MONTH_W-1:0] NOV = 4'd11;
  localparam logic [MONTH_W-1:0] DEC = 4'd12;

  localparam logic [DAY_W-1:0] LEN28 = 5'd28;
  localparam logic [DAY_W-1:0] LEN29 = 5'd29;
  localparam logic [DAY_W-1:0] LEN30 = 5'd30;
  localparam logic [DAY_W-1:0] LEN31 = 5'd31;

  typedef struct packed {
    logic [DAY_W-1:0]   day;
    logic [MONTH_W-1:0] month;
    logic [YEAR_W-1:0]  year;
  } date_t;

  // Two-digit year inside 2000-2099: every multiple of four is a leap year.
  function automatic logic is_leap(input logic [YEAR_W-1:0] yr);
    return (yr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/calendar_sequencer_month_days_lut.sv
// Month length lookup: 28/29/30/31 for months 1..12, 0 for illegal month codes.
// Latency: purely combinational.
// Backpressure: none.
// Ports: month (1..12 legal), leap (year is leap), len (days in that month).
module month_days_lut
  import calendar_sequencer_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic               leap,
  output logic [DAY_W-1:0]   len
);

  always_comb begin
    len = '0;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: len = LEN31;
      APR, JUN, SEP, NOV:                len = LEN30;
      FEB:                               len = leap ? LEN29 : LEN28;
      // 0 and 13..15 give 0 so a load validator can reject them with one compare.
      default:                           len = '0;
    endcase
  end

endmodule

// File: rtl/calendar_sequencer.sv
// Day/month/year calendar advancing one day per day_tick, with validated synchronous load.
// Latency: one cycle from tick/load to new date and to month_end/year_end/load_err pulses.
// Backpressure: none; every tick is consumed, a tick coinciding with load is dropped.
// Ports: clk, rst (async high); day_tick, load, ld_day/ld_month/ld_year in;
//        day/month/year, days_in_month, leap, month_end, year_end, load_err out.
module calendar_sequencer
  import calendar_sequencer_pkg::*;
#(
  parameter int YEAR_MAX  = 99,
  parameter int RST_DAY   = 1,
  parameter int RST_MONTH = 1,
  parameter int RST_YEAR  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               day_tick,
  input  logic               load,
  input  logic [DAY_W-1:0]   ld_day,
  input  logic [MONTH_W-1:0] ld_month,
  input  logic [YEAR_W-1:0]  ld_year,
  output logic [DAY_W-1:0]   day,
  output logic [MONTH_W-1:0] month,
  output logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   days_in_month,
  output logic               leap,
  output logic               month_end,
  output logic               year_end,
  output logic               load_err
);

  localparam logic [YEAR_W-1:0] YEAR_MAX_V = YEAR_W'(YEAR_MAX);

  localparam date_t RST_DATE = '{
    day:   DAY_W'(RST_DAY),
    month: MONTH_W'(RST_MONTH),
    year:  YEAR_W'(RST_YEAR)
  };

  date_t            date_q;
  logic [DAY_W-1:0] cur_len;
  logic [DAY_W-1:0] ld_len;
  logic             ld_leap;
  logic             ld_valid;

  assign day   = date_q.day;
  assign month = date_q.month;
  assign year  = date_q.year;

  assign leap    = is_leap(date_q.year);
  assign ld_leap = is_leap(ld_year);

  month_days_lut u_cur_lut (
    .month (date_q.month),
    .leap  (leap),
    .len   (cur_len)
  );

  month_days_lut u_ld_lut (
    .month (ld_month),
    .leap  (ld_leap),
    .len   (ld_len)
  );

  assign days_in_month = cur_len;

  // A zero length from the lookup means the month code itself is illegal.
  assign ld_valid = (ld_len != '0) &&
                    (ld_year <= YEAR_MAX_V) &&
                    (ld_day != '0) &&
                    (ld_day <= ld_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      date_q    <= RST_DATE;
      month_end <= 1'b0;
      year_end  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      month_end <= 1'b0;
      year_end  <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        // Load wins; a simultaneous tick is discarded, not deferred.
        if (ld_valid) begin
          date_q.day   <= ld_day;
          date_q.month <= ld_month;
          date_q.year  <= ld_year;
        end else begin
          load_err <= 1'b1;
        end
      end else if (day_tick) begin
        if (date_q.day < cur_len) begin
          date_q.day <= date_q.day + 5'd1;
        end else begin
          date_q.day <= 5'd1;
          month_end  <= 1'b1;
          if (date_q.month == DEC) begin
            date_q.month <= JAN;
            year_end     <= 1'b1;
            date_q.year  <= (date_q.year == YEAR_MAX_V) ? '0 : date_q.year + 7'd1;
          end else begin
            date_q.month <= date_q.month + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/calendar_sequencer.md
Name: calendar_sequencer

Overview:
- Sequences a day/month/year calendar, one day per qualified tick.
- Uses a month-length lookup that extends the existing month-has-31-days decode with 30-day months and February leap handling.
- Sits between a day-rate strobe source and date display/compare logic.
- Supports synchronous date load with validation.

Parameters:
- YEAR_MAX, 99, last year value before wrap to 0; two-digit year, 2000-2099 span.
- RST_DAY, 1, day value loaded on reset.
- RST_MONTH, 1, month value loaded on reset.
- RST_YEAR, 0, year value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- day_tick  in  1  single-cycle strobe; advance date by one day.
- load  in  1  single-cycle strobe; request load of ld_day/ld_month/ld_year.
- ld_day  in  5  day to load, 1..31.
- ld_month  in  4  month to load, 1..12.
- ld_year  in  7  year to load, 0..YEAR_MAX.
- day  out  5  current day, 1..31.
- month  out  4  current month, 1..12.
- year  out  7  current year, 0..YEAR_MAX.
- days_in_month  out  5  length of the current month, combinational from month/year: 28, 29, 30 or 31.
- leap  out  1  current year is leap: year[1:0]==0.
- month_end  out  1  one-cycle pulse, registered with the month rollover.
- year_end  out  1  one-cycle pulse, registered with the Dec 31 -> Jan 1 rollover.
- load_err  out  1  one-cycle pulse; the last load was rejected.

Behaviour:
- Reset (async, rst=1):
  - day=RST_DAY, month=RST_MONTH, year=RST_YEAR.
  - month_end=0, year_end=0, load_err=0.
  - Reset mid-operation overrides everything; no pending tick or load survives.
- Month length rule:
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - Month 2: 29 if leap, else 28.
  - Months 0 and 13-15: 0 (never reachable in state; used only for load validation).
- Tick, load=0, day_tick=1, one-cycle latency:
  - day < days_in_month: day += 1.
  - day == days_in_month: day = 1, month_end = 1 next cycle.
  - If also month == 12: month = 1, year_end = 1 next cycle.
  - year == YEAR_MAX rolls to 0; otherwise year += 1.
  - Otherwise, on month rollover with month != 12: month += 1.
- Pulses: month_end, year_end and load_err are high exactly one cycle after the causing edge, then return to 0 unless re-caused.
- Load, load=1:
  - load has priority over day_tick in the same cycle; the tick is discarded, not deferred.
  - Valid when ld_month is 1..12, ld_year <= YEAR_MAX, and ld_day is 1..len(ld_month, ld_year[1:0]==0).
  - Valid load: registers take the new values next cycle; no pulses.
  - Invalid load: state unchanged; load_err = 1 next cycle.
- Back-to-back ticks on consecutive cycles are legal; each advances one day.
- No state outside the legal date range is ever reachable.

Decomposition:
- Shared package/include:
  - month constants JAN..DEC, 4-bit.
  - length constants LEN28/LEN29/LEN30/LEN31, 5-bit.
  - DAY_W=5, MONTH_W=4, YEAR_W=7.
- Sub-module month_days_lut: combinational; inputs month[3:0] and leap; output len[4:0].
- Instantiate month_days_lut twice: once for current state, once for load validation.

Test Plan:
- Reset then 31 ticks from 1/1/00 -> day 2..31, then 1/2/00 with month_end pulse one cycle; year_end stays 0.
- Load 28/2/01, one tick -> 1/3/01 with month_end. Load 28/2/04, tick -> 29/2/04, tick -> 1/3/04.
- Load 31/12/99, tick -> 1/1/00; month_end and year_end both high for one cycle.
- Load 31/4/05, load 0/6/05, load 15/13/05, load 1/1/100 -> each gives a load_err pulse; date unchanged. Load 29/2/05 -> load_err; load 29/2/08 accepted.
- load and day_tick in the same cycle with 30/6/10 -> result exactly 30/6/10, no month_end. Consecutive ticks from 29/4/10 -> 30/4/10, 1/5/10.
- Assert rst asynchronously mid-tick-stream from 15/8/20 -> outputs immediately 1/1/00, pulses low. Release rst, tick -> 2/1/00.
